// File: rtl/key_loader.sv
// Key loader: assembles a 128/192/256-bit cipher key from 32-bit words and runs a key-generation pass on the AES control unit.
// Optional KEY_LOADER_ZEROIZE_EN clears the key as the wait for the control unit ends.
//
// state  | meaning
// IDLE   | ready for the first key word
// LOAD   | collecting the remaining key words
// LAUNCH | keygen held, waiting for cu_ready to pulse run
// WAIT   | keygen held, waiting for cu_done or timeout
module key_loader #(
    parameter int TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [31:0]  in_data,
    output logic         in_ready,
    input  logic [1:0]   mode_in,
    input  logic         enc_in,
    input  logic         cu_ready,
    input  logic         cu_done,
    output logic         run,
    output logic         keygen,
    output logic [1:0]   mode,
    output logic         enc,
    output logic [255:0] key,
    output logic         key_valid,
    output logic         err
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        ST_IDLE   = 4'b0001,
        ST_LOAD   = 4'b0010,
        ST_LAUNCH = 4'b0100,
        ST_WAIT   = 4'b1000
    } state_t;

    state_t         state_q, state_d;
    logic [255:0]   key_q, key_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [1:0]     mode_q, mode_d;
    logic           enc_q, enc_d;
    logic           kv_q, kv_d;
    logic [TW-1:0]  tmo_q, tmo_d;

    logic [3:0]     need;
    logic [3:0]     cnt_inc;
    logic           tmo_hit;

    // Modes 0 and 1 both mean AES128.
    always_comb begin
        case (mode_q)
            2'd3:    need = 4'd8;
            2'd2:    need = 4'd6;
            default: need = 4'd4;
        endcase
    end

    assign cnt_inc = cnt_q + 4'd1;
    assign tmo_hit = (tmo_q == TMO_LAST);

    assign in_ready = (state_q == ST_IDLE) || (state_q == ST_LOAD);
    assign keygen   = (state_q == ST_LAUNCH) || (state_q == ST_WAIT);
    assign run      = (state_q == ST_LAUNCH) && cu_ready;
    assign err      = (state_q == ST_WAIT) && !cu_done && tmo_hit;

    assign key       = key_q;
    assign mode      = mode_q;
    assign enc       = enc_q;
    assign key_valid = kv_q;

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        enc_d   = enc_q;
        kv_d    = kv_q;
        tmo_d   = tmo_q;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    mode_d  = mode_in;
                    enc_d   = enc_in;
                    key_d   = {in_data, 224'b0};
                    cnt_d   = 4'd1;
                    kv_d    = 1'b0;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (in_valid) begin
                    for (int i = 1; i < 8; i++) begin
                        if (cnt_q == 4'(i)) key_d[255-32*i -: 32] = in_data;
                    end
                    cnt_d = cnt_inc;
                    if (cnt_inc == need) state_d = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                if (cu_ready) begin
                    tmo_d   = '0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                tmo_d = tmo_q + 1'b1;
                // Done wins over a timeout landing in the same cycle.
                if (cu_done) begin
                    kv_d    = 1'b1;
                    state_d = ST_IDLE;
`ifdef KEY_LOADER_ZEROIZE_EN
                    key_d   = '0;
`endif
                end else if (tmo_hit) begin
                    state_d = ST_IDLE;
`ifdef KEY_LOADER_ZEROIZE_EN
                    key_d   = '0;
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            key_q   <= '0;
            cnt_q   <= '0;
            mode_q  <= '0;
            enc_q   <= 1'b0;
            kv_q    <= 1'b0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            enc_q   <= enc_d;
            kv_q    <= kv_d;
            tmo_q   <= tmo_d;
        end
    end

endmodule
